// File: rtl/cnt5_dec.sv
// cnt5_dec: receive-side decoder for the mod-5 up/down count code
module cnt5_dec #(
  parameter int POS_W = 8,
  parameter int RELOCK_N = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       cnt_in,
  input  logic             valid,
  input  logic             pos_clr,
  output logic             dir,
  output logic             dir_valid,
  output logic             ovf,
  output logic             unf,
  output logic             err,
  output logic             locked,
  output logic [POS_W-1:0] pos,
  output logic [7:0]       err_cnt
);
  localparam logic [1:0] IDLE = 2'd0, LOCK = 2'd1, ERR = 2'd2;
  logic [1:0] state;
  logic [2:0] prev, rel, nxt_up, nxt_dn;
  logic code_ok, up, dn, step_ok;
  logic [7:0] err_inc;
  // classify the sample against the last accepted code
  always_comb begin
    code_ok = cnt_in <= 3'd4;
    nxt_up = prev == 3'd4 ? 3'd0 : prev + 3'd1;
    nxt_dn = prev == 3'd0 ? 3'd4 : prev - 3'd1;
    up = code_ok && cnt_in == nxt_up;
    dn = code_ok && cnt_in == nxt_dn;
    step_ok = up || dn;
    err_inc = err_cnt == 8'hff ? err_cnt : err_cnt + 8'd1;
  end
  assign locked = state == LOCK;
  // tracking FSM; pulses default low and fire only on a valid sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      prev <= '0;
      rel <= '0;
      pos <= '0;
      err_cnt <= '0;
      dir <= 1'b0;
      dir_valid <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
      err <= 1'b0;
    end else begin
      dir_valid <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
      err <= 1'b0;
      if (pos_clr) pos <= '0;
      if (valid) begin
        case (state)
          IDLE: begin
            if (code_ok) begin
              prev <= cnt_in;
              state <= LOCK;
            end else begin
              err <= 1'b1;
              err_cnt <= err_inc;
            end
          end
          LOCK: begin
            if (step_ok) begin
              dir <= up;
              dir_valid <= 1'b1;
              ovf <= up && prev == 3'd4;
              unf <= dn && prev == 3'd0;
              prev <= cnt_in;
              if (!pos_clr) pos <= pos + (up ? POS_W'(1) : '1);
            end else begin
              err <= 1'b1;
              err_cnt <= err_inc;
              rel <= '0;
              state <= ERR;
              if (code_ok) prev <= cnt_in;
            end
          end
          ERR: begin
            if (step_ok) begin
              prev <= cnt_in;
              rel <= rel + 3'd1;
              if (rel == 3'(RELOCK_N - 1)) state <= LOCK;
            end else begin
              err <= 1'b1;
              err_cnt <= err_inc;
              rel <= '0;
              if (code_ok) prev <= cnt_in;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cnt5_dec.sv
// tb_cnt5_dec: directed self-checking bench for cnt5_dec
module tb_cnt5_dec;
  logic clk = 1'b0, reset_n = 1'b0, valid = 1'b0, pos_clr = 1'b0;
  logic [2:0] cnt_in = '0, cur;
  logic dir, dir_valid, ovf, unf, err, locked;
  logic [7:0] pos, err_cnt;
  int errors = 0, checks = 0;

  cnt5_dec #(.POS_W(8), .RELOCK_N(2)) dut (
    .clk(clk), .reset_n(reset_n), .cnt_in(cnt_in), .valid(valid), .pos_clr(pos_clr),
    .dir(dir), .dir_valid(dir_valid), .ovf(ovf), .unf(unf), .err(err),
    .locked(locked), .pos(pos), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: run did not finish, required completion");
    $fatal(1);
  end

  // present one valid sample; outputs are observed 1 ns after the sampling edge
  task automatic drive(input logic [2:0] c, input logic clr = 1'b0);
    @(negedge clk);
    cnt_in = c;
    valid = 1'b1;
    pos_clr = clr;
    @(posedge clk);
    #1;
    valid = 1'b0;
    pos_clr = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    checks++;
    if ({dir, dir_valid, ovf, unf, err, locked, pos, err_cnt} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {dir, dir_valid, ovf, unf, err, locked, pos, err_cnt});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_up;
    logic [2:0] seq [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    for (int i = 0; i < 7; i++) begin
      drive(seq[i]);
      checks++;
      if (dir_valid !== (i != 0)) begin
        errors++;
        $display("FAIL up_dv[%0d]: got %b required %b", i, dir_valid, i != 0);
      end
      checks++;
      if (ovf !== (i == 5)) begin
        errors++;
        $display("FAIL up_ovf[%0d]: got %b required %b", i, ovf, i == 5);
      end
      checks++;
      if (err !== 1'b0 || locked !== 1'b1) begin
        errors++;
        $display("FAIL up_err_locked[%0d]: got err=%b locked=%b required 0 1", i, err, locked);
      end
      if (i != 0) begin
        checks++;
        if (dir !== 1'b1) begin
          errors++;
          $display("FAIL up_dir[%0d]: got %b required 1", i, dir);
        end
      end
    end
    checks++;
    if (pos !== 8'd6) begin
      errors++;
      $display("FAIL up_pos: got %0d required 6", pos);
    end
  endtask

  task automatic test_down;
    logic [2:0] seq [3] = '{3'd0, 3'd4, 3'd3};
    for (int i = 0; i < 3; i++) begin
      drive(seq[i]);
      checks++;
      if (dir !== 1'b0 || dir_valid !== 1'b1 || locked !== 1'b1) begin
        errors++;
        $display("FAIL down_step[%0d]: got dir=%b dv=%b locked=%b required 0 1 1", i, dir, dir_valid, locked);
      end
      checks++;
      if (unf !== (i == 1)) begin
        errors++;
        $display("FAIL down_unf[%0d]: got %b required %b", i, unf, i == 1);
      end
    end
    checks++;
    if (pos !== 8'd3) begin
      errors++;
      $display("FAIL down_pos: got %0d required 3", pos);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dir_valid !== 1'b0 || pos !== 8'd3) begin
      errors++;
      $display("FAIL idle_cycle: got dv=%b pos=%0d required 0 3", dir_valid, pos);
    end
  endtask

  task automatic test_err_step;
    drive(3'd2);
    checks++;
    if (pos !== 8'd2 || unf !== 1'b0) begin
      errors++;
      $display("FAIL to_two: got pos=%0d unf=%b required 2 0", pos, unf);
    end
    drive(3'd2);
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || dir_valid !== 1'b0) begin
      errors++;
      $display("FAIL repeat_err: got err=%b cnt=%0d locked=%b dv=%b required 1 1 0 0", err, err_cnt, locked, dir_valid);
    end
    drive(3'd3);
    checks++;
    if (err !== 1'b0 || locked !== 1'b0 || dir_valid !== 1'b0) begin
      errors++;
      $display("FAIL relock_1: got err=%b locked=%b dv=%b required 0 0 0", err, locked, dir_valid);
    end
    drive(3'd4);
    checks++;
    if (locked !== 1'b1 || dir_valid !== 1'b0 || pos !== 8'd2) begin
      errors++;
      $display("FAIL relock_2: got locked=%b dv=%b pos=%0d required 1 0 2", locked, dir_valid, pos);
    end
    drive(3'd0);
    checks++;
    if (ovf !== 1'b1 || dir_valid !== 1'b1 || pos !== 8'd3) begin
      errors++;
      $display("FAIL post_relock: got ovf=%b dv=%b pos=%0d required 1 1 3", ovf, dir_valid, pos);
    end
  endtask

  task automatic test_illegal_code;
    drive(3'd6);
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd2 || locked !== 1'b0) begin
      errors++;
      $display("FAIL code6: got err=%b cnt=%0d locked=%b required 1 2 0", err, err_cnt, locked);
    end
    drive(3'd2);
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd3) begin
      errors++;
      $display("FAIL jump_in_err: got err=%b cnt=%0d required 1 3", err, err_cnt);
    end
    drive(3'd3);
    checks++;
    if (locked !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL err_relock_1: got locked=%b err=%b required 0 0", locked, err);
    end
    drive(3'd4);
    checks++;
    if (locked !== 1'b1 || pos !== 8'd3) begin
      errors++;
      $display("FAIL err_relock_2: got locked=%b pos=%0d required 1 3", locked, pos);
    end
    cur = 3'd4;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 124; i++) begin
      cur = cur == 3'd4 ? 3'd0 : cur + 3'd1;
      drive(cur);
    end
    checks++;
    if (pos !== 8'd127) begin
      errors++;
      $display("FAIL pos_127: got %0d required 127", pos);
    end
    cur = cur == 3'd4 ? 3'd0 : cur + 3'd1;
    drive(cur);
    checks++;
    if (pos !== 8'h80) begin
      errors++;
      $display("FAIL pos_wrap: got %h required 80", pos);
    end
    cur = cur == 3'd4 ? 3'd0 : cur + 3'd1;
    drive(cur, 1'b1);
    checks++;
    if (pos !== 8'd0 || dir_valid !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL pos_clr: got pos=%0d dv=%b ovf=%b required 0 1 1", pos, dir_valid, ovf);
    end
  endtask

  task automatic test_async_reset;
    drive(3'd7);
    drive(3'd7);
    drive(3'd1);
    drive(3'd2);
    checks++;
    if (err_cnt !== 8'd5 || locked !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got cnt=%0d locked=%b required 5 1", err_cnt, locked);
    end
    drive(3'd3);
    checks++;
    if (pos !== 8'd1 || dir !== 1'b1 || dir_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_step: got pos=%0d dir=%b dv=%b required 1 1 1", pos, dir, dir_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({dir, dir_valid, ovf, unf, err, locked, pos, err_cnt} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0", {dir, dir_valid, ovf, unf, err, locked, pos, err_cnt});
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(3'd2);
    checks++;
    if (dir_valid !== 1'b0 || locked !== 1'b1 || pos !== 8'd0) begin
      errors++;
      $display("FAIL post_reset: got dv=%b locked=%b pos=%0d required 0 1 0", dir_valid, locked, pos);
    end
  endtask

  task automatic test_err_sat;
    for (int i = 0; i < 260; i++) drive(3'd5);
    checks++;
    if (err_cnt !== 8'd255 || err !== 1'b1) begin
      errors++;
      $display("FAIL err_sat: got cnt=%0d err=%b required 255 1", err_cnt, err);
    end
  endtask

  initial begin
    test_reset;
    test_up;
    test_down;
    test_err_step;
    test_illegal_code;
    test_wrap;
    test_async_reset;
    test_err_sat;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
